// File: rtl/prim_clock_gate_ctrl_if.sv
// prim_clock_gate_ctrl_if: handshake and status bundle between a gated unit and its clock-gate controller.
interface prim_clock_gate_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             enable_i;
    logic             busy_i;
    logic             wake_i;
    logic             sleep_ack_i;
    logic             sleep_req_o;
    logic             clk_en_o;
    logic             ready_o;
    logic [CNT_W-1:0] gate_cnt_o;
    modport master (
        output enable_i, busy_i, wake_i, sleep_ack_i,
        input  sleep_req_o, clk_en_o, ready_o, gate_cnt_o
    );
    modport slave (
        input  enable_i, busy_i, wake_i, sleep_ack_i,
        output sleep_req_o, clk_en_o, ready_o, gate_cnt_o
    );
endinterface

// File: rtl/prim_clock_gate_ctrl.sv
// prim_clock_gate_ctrl: idle-driven sleep handshake producing a registered enable for a clock-gating cell.
module prim_clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input logic                  clk_i,
    input logic                  rst_i,
    prim_clock_gate_ctrl_if.slave bus
);
    localparam int MX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
    localparam logic [1:0] RUN = 2'd0, SREQ = 2'd1, GATED = 2'd2, WAKE = 2'd3;
    logic [1:0]       r_state, w_nstate;
    logic [CW-1:0]    r_cnt, w_ncnt;
    logic [CNT_W-1:0] r_gate_cnt;
    logic             r_clk_en, r_ready, r_sleep_req;
    logic             w_idle, w_gate;
    assign w_idle = !bus.busy_i && !bus.wake_i && bus.enable_i;
    // r_cnt serves as idle counter in RUN and wake counter in WAKE; it is zero elsewhere
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = '0;
        w_gate   = 1'b0;
        case (r_state)
            RUN: begin
                w_nstate = (w_idle && r_cnt == IDLE_LAST) ? SREQ : RUN;
                w_ncnt   = (w_idle && r_cnt != IDLE_LAST) ? r_cnt + 1'b1 : '0;
            end
            SREQ: begin
                w_nstate = !w_idle ? RUN : bus.sleep_ack_i ? GATED : SREQ;
                w_gate   = w_idle && bus.sleep_ack_i;
            end
            GATED: w_nstate = (bus.wake_i || bus.busy_i || !bus.enable_i) ? WAKE : GATED;
            default: begin
                w_nstate = (r_cnt == WAKE_LAST) ? RUN : WAKE;
                w_ncnt   = (r_cnt == WAKE_LAST) ? '0 : r_cnt + 1'b1;
            end
        endcase
    end
    // outputs are decoded from the next state so each one is a clean flop output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_gate_cnt  <= '0;
            r_clk_en    <= 1'b1;
            r_ready     <= 1'b1;
            r_sleep_req <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_cnt       <= w_ncnt;
            r_gate_cnt  <= (w_gate && !(&r_gate_cnt)) ? r_gate_cnt + 1'b1 : r_gate_cnt;
            r_clk_en    <= w_nstate != GATED;
            r_ready     <= w_nstate == RUN;
            r_sleep_req <= w_nstate == SREQ;
        end
    end
    assign bus.clk_en_o    = r_clk_en;
    assign bus.ready_o     = r_ready;
    assign bus.sleep_req_o = r_sleep_req;
    assign bus.gate_cnt_o  = r_gate_cnt;
endmodule
